// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//   Arbitrates NUM_CORES single-cycle cores onto one shared memory port.
//   A core request is eligible only when it is word aligned and falls inside
//   the 128-byte window selected by BASE_ADDRESS (address bits 31:7). Grant is
//   combinational. Cores are served round-robin, and the lock input holds
//   ownership for read-modify-write sequences.
//
// Parameters
//   NUM_CORES     number of requesting cores (2..8)
//   BASE_ADDRESS  value compared against address bits 31:7
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req/we/lock         per-core request, write enable, hold-ownership
//   addr/wdata          per-core address and store data, 32 bits per core
//   grant/stall         per-core one-hot grant and freeze-PC indication
//   rdata               mem_rdata broadcast while a grant is active, else 0
//   mem_en/mem_we       shared memory port enable and write strobe
//   mem_addr/mem_wdata  shared memory port address and store data
//   mem_rdata           shared memory combinational read data
//   grant_count         per-core saturating granted-cycle counters (16 bits each)
//   conflict_count      saturating count of cycles with any stall
//
// Build option
//   SHARED_ARB_STATS_EN  adds grant_count / conflict_count and their counters
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int unsigned NUM_CORES    = 4,
  parameter logic [24:0] BASE_ADDRESS = 25'd1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CORES-1:0]     req,
  input  logic [NUM_CORES-1:0]     we,
  input  logic [NUM_CORES-1:0]     lock,
  input  logic [NUM_CORES*32-1:0]  addr,
  input  logic [NUM_CORES*32-1:0]  wdata,
  output logic [NUM_CORES-1:0]     grant,
  output logic [NUM_CORES-1:0]     stall,
  output logic [31:0]              rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
`ifdef SHARED_ARB_STATS_EN
  output logic [NUM_CORES*16-1:0]  grant_count,
  output logic [15:0]              conflict_count,
`endif
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned PW = $clog2(NUM_CORES);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] grant_raw;
  logic [PW-1:0]        start;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        sel;
  logic                 found;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (32'(v) == NUM_CORES - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      elig[k] = req[k]
             && (addr[32*k +: 2] == 2'b00)
             && (addr[32*k+7 +: 25] == BASE_ADDRESS);
    end
  end

  // When a locked owner stops presenting an eligible request, the cycle is
  // not wasted: the scan restarts at owner+1 immediately, which is also the
  // pointer value the block would have returned to ARB with.
  always_comb begin
    grant_raw = '0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    start     = ptr_q;
    cand      = '0;
    sel       = '0;
    found     = 1'b0;
    if (state_q == LOCKED && elig[owner_q]) begin
      grant_raw[owner_q] = 1'b1;
      if (!lock[owner_q]) begin
        state_d = ARB;
        ptr_d   = wrap_inc(owner_q);
      end
    end else begin
      start = (state_q == LOCKED) ? wrap_inc(owner_q) : ptr_q;
      cand  = start;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!found && elig[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
        cand = wrap_inc(cand);
      end
      state_d = ARB;
      ptr_d   = start;
      if (found) begin
        grant_raw[sel] = 1'b1;
        if (lock[sel]) begin
          state_d = LOCKED;
          owner_d = sel;
        end else begin
          ptr_d = wrap_inc(sel);
        end
      end
    end
  end

  // Reset gates the combinational outputs so nothing is served while held.
  always_comb begin
    grant = reset ? '0 : grant_raw;
    stall = reset ? '0 : (elig & ~grant_raw);
  end

  always_comb begin
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (grant[k]) begin
        mem_we    = we[k];
        mem_addr  = addr[32*k +: 32];
        mem_wdata = wdata[32*k +: 32];
      end
    end
    rdata = mem_en ? mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef SHARED_ARB_STATS_EN
  logic [15:0] gcnt_q [NUM_CORES];
  logic [15:0] conflict_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        gcnt_q[k] <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        if (grant[k] && gcnt_q[k] != '1) begin
          gcnt_q[k] <= gcnt_q[k] + 1'b1;
        end
      end
      if (|stall && conflict_q != '1) begin
        conflict_q <= conflict_q + 1'b1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      grant_count[16*k +: 16] = gcnt_q[k];
    end
    conflict_count = conflict_q;
  end
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//   Directed self-checking bench for shared_mem_arbiter with four cores and the
//   window at byte addresses 128..255. Inputs change 1 time unit after the
//   rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req, we, lock;
  logic [127:0] addr, wdata;
  logic [3:0]   grant, stall;
  logic [31:0]  rdata, mem_addr, mem_wdata, mem_rdata;
  logic         mem_en, mem_we;
`ifdef SHARED_ARB_STATS_EN
  logic [63:0]  grant_count;
  logic [15:0]  conflict_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  shared_mem_arbiter #(
    .NUM_CORES   (4),
    .BASE_ADDRESS(25'd1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr          (addr),
    .wdata         (wdata),
    .grant         (grant),
    .stall         (stall),
    .rdata         (rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
`ifdef SHARED_ARB_STATS_EN
    .grant_count   (grant_count),
    .conflict_count(conflict_count),
`endif
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic set_core(input int k, input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
    req[k]            = r;
    we[k]             = w;
    lock[k]           = l;
    addr[32*k +: 32]  = a;
    wdata[32*k +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    mem_rdata = 32'hDEAD_BEEF;
    clear_inputs();
    reset = 1'b1;

    // Outputs held quiet during reset even with an eligible store pending.
    #1;
    set_core(0, 1, 1, 0, 32'd128, 32'd7);
    #2;
    check("rst_grant", grant, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    clear_inputs();

    // Four-way continuous load contention: round robin from core 0.
    for (int c = 0; c < 4; c++) set_core(c, 1, 0, 0, 32'd128, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #4;
      check("rr_grant", grant, seq[i]);
      check("rr_stall", stall, 4'hF & ~seq[i]);
      check("rr_mem_addr", mem_addr, 32'd128);
      check("rr_rdata", rdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    do_reset();

    // Lone store from core 2.
    set_core(2, 1, 1, 0, 32'd148, 32'd325);
    #4;
    check("st_grant", grant, 4'b0100);
    check("st_mem_en", mem_en, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_addr", mem_addr, 32'd148);
    check("st_mem_wdata", mem_wdata, 32'd325);
    check("st_stall", stall, 0);
    next_cycle();
    clear_inputs();

    // Out-of-window, misaligned and above-window requests are ignored.
    set_core(0, 1, 0, 0, 32'd0, 32'd0);
    #4;
    check("oow_grant", grant, 0);
    check("oow_stall", stall, 0);
    check("oow_mem_en", mem_en, 0);
    check("oow_rdata", rdata, 0);
    check("oow_mem_addr", mem_addr, 0);
    set_core(0, 1, 0, 0, 32'd130, 32'd0);
    #1;
    check("misalign_grant", grant, 0);
    set_core(0, 1, 0, 0, 32'd256, 32'd0);
    #1;
    check("above_grant", grant, 0);
    check("above_stall", stall, 0);
    next_cycle();
    do_reset();

    // Core 1 locks for three cycles, core 3 waits and is served on release.
    set_core(1, 1, 0, 1, 32'd136, 32'd0);
    set_core(3, 1, 0, 0, 32'd200, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check("lock_grant", grant, 4'b0010);
      check("lock_stall", stall, 4'b1000);
      next_cycle();
    end
    set_core(1, 0, 0, 0, 32'd136, 32'd0);
    #4;
    check("unlock_grant", grant, 4'b1000);
    check("unlock_stall", stall, 0);
    next_cycle();
    do_reset();

    // Owner drops lock but still requests: served, then pointer moves past it.
    set_core(1, 1, 0, 1, 32'd136, 32'd0);
    #4;
    check("own_lock_grant", grant, 4'b0010);
    next_cycle();
    set_core(1, 1, 0, 0, 32'd136, 32'd0);
    set_core(0, 1, 0, 0, 32'd128, 32'd0);
    set_core(2, 1, 0, 0, 32'd132, 32'd0);
    #4;
    check("own_exit_grant", grant, 4'b0010);
    check("own_exit_stall", stall, 4'b0101);
    next_cycle();
    set_core(1, 0, 0, 0, 32'd136, 32'd0);
    #4;
    check("post_exit_grant", grant, 4'b0100);
    check("post_exit_stall", stall, 4'b0001);
    next_cycle();
    do_reset();

    // Reset in the middle of a lock owned by core 2.
    set_core(2, 1, 1, 1, 32'd160, 32'd9);
    #4;
    check("own2_grant", grant, 4'b0100);
    next_cycle();
    #4;
    check("own2_hold_grant", grant, 4'b0100);
    check("own2_mem_we", mem_we, 1);
    reset = 1'b1;
    #1;
    check("midlock_rst_grant", grant, 0);
    check("midlock_rst_stall", stall, 0);
    check("midlock_rst_mem_en", mem_en, 0);
    check("midlock_rst_mem_we", mem_we, 0);
    next_cycle();
    reset = 1'b0;
    set_core(0, 1, 0, 0, 32'd128, 32'd0);
    #4;
    check("post_rst_grant", grant, 4'b0001);
    check("post_rst_stall", stall, 4'b0100);
    next_cycle();
    clear_inputs();

`ifdef SHARED_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 4; c++) set_core(c, 1, 0, 0, 32'd128, 32'd0);
    for (int i = 0; i < 10; i++) begin
      #4;
      next_cycle();
    end
    clear_inputs();
    #4;
    check("gcnt0", {16'd0, grant_count[15:0]}, 32'd3);
    check("gcnt1", {16'd0, grant_count[31:16]}, 32'd3);
    check("gcnt2", {16'd0, grant_count[47:32]}, 32'd2);
    check("gcnt3", {16'd0, grant_count[63:48]}, 32'd2);
    check("conflicts", {16'd0, conflict_count}, 32'd10);
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
